// File: rtl/sram_access_controller.sv
// Bus-cycle sequencer between the 68k asynchronous bus and four 32K-word SRAM blocks.
// Latches the qualified cycle, sequences enables/strobes over programmable waits, returns DTACK.
module sram_access_controller #(
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 1
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic [16:0] Address,
    input  logic        SRamSelect_H,
    input  logic        AS_L,
    input  logic        UDS_L,
    input  logic        LDS_L,
    input  logic        WE_L,
    output logic [3:0]  BlockEn_H,
    output logic [14:0] SRamAddr,
    output logic        OE_H,
    output logic [1:0]  ByteWE_H,
    output logic        DtackOut_L
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [1:0] blk;
    logic       is_write;
    logic [1:0] lanes;
    logic       start;
    logic       active;

    assign start  = !AS_L && SRamSelect_H && (!UDS_L || !LDS_L);
    assign active = (state == ST_WAIT) || (state == ST_ACK);

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            blk      <= '0;
            SRamAddr <= '0;
            is_write <= 1'b0;
            lanes    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        SRamAddr <= Address[14:0];
                        blk      <= Address[16:15];
                        is_write <= !WE_L;
                        lanes    <= {!UDS_L, !LDS_L};
                        cnt      <= WE_L ? RD_LOAD : WR_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Abort takes priority over the wait count; DTACK is never issued.
                    if (AS_L) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (AS_L) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        BlockEn_H = '0;
        if (active) begin
            BlockEn_H[blk] = 1'b1;
        end
    end

    // Write strobes drop on entry to ACK so the write closes with address still stable.
    assign OE_H       = active && !is_write;
    assign ByteWE_H   = (state == ST_WAIT && is_write) ? lanes : 2'b00;
    assign DtackOut_L = (state != ST_ACK);

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller: three builds (1/1, 0/0, 3/3 waits) share one bus.
module tb_sram_access_controller;

    logic        Clock = 1'b0;
    logic        Reset_L = 1'b0;
    logic [16:0] Address = '0;
    logic        SRamSelect_H = 1'b0;
    logic        AS_L = 1'b1;
    logic        UDS_L = 1'b1;
    logic        LDS_L = 1'b1;
    logic        WE_L = 1'b1;

    logic [3:0]  blk_a, blk_z, blk_t;
    logic [14:0] addr_a, addr_z, addr_t;
    logic        oe_a, oe_z, oe_t;
    logic [1:0]  we_a, we_z, we_t;
    logic        dtack_a, dtack_z, dtack_t;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 Clock = ~Clock;

    sram_access_controller #(.READ_WAIT(1), .WRITE_WAIT(1)) dut (
        .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .WE_L(WE_L),
        .BlockEn_H(blk_a), .SRamAddr(addr_a), .OE_H(oe_a), .ByteWE_H(we_a), .DtackOut_L(dtack_a));

    sram_access_controller #(.READ_WAIT(0), .WRITE_WAIT(0)) dut_zero (
        .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .WE_L(WE_L),
        .BlockEn_H(blk_z), .SRamAddr(addr_z), .OE_H(oe_z), .ByteWE_H(we_z), .DtackOut_L(dtack_z));

    sram_access_controller #(.READ_WAIT(3), .WRITE_WAIT(3)) dut_three (
        .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .WE_L(WE_L),
        .BlockEn_H(blk_t), .SRamAddr(addr_t), .OE_H(oe_t), .ByteWE_H(we_t), .DtackOut_L(dtack_t));

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic bus_start(input logic [16:0] a, input logic we_l, input logic uds_l, input logic lds_l);
        Address = a; WE_L = we_l; UDS_L = uds_l; LDS_L = lds_l; SRamSelect_H = 1'b1; AS_L = 1'b0;
    endtask

    task automatic bus_release();
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; WE_L = 1'b1; SRamSelect_H = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (blk_a !== 4'b0000) begin n_fails++; $display("FAIL reset_blk: got %b expected 0000", blk_a); end
        n_checks++; if (addr_a !== 15'h0) begin n_fails++; $display("FAIL reset_addr: got %h expected 0000", addr_a); end
        n_checks++; if (oe_a !== 1'b0) begin n_fails++; $display("FAIL reset_oe: got %b expected 0", oe_a); end
        n_checks++; if (we_a !== 2'b00) begin n_fails++; $display("FAIL reset_we: got %b expected 00", we_a); end
        n_checks++; if (dtack_a !== 1'b1) begin n_fails++; $display("FAIL reset_dtack: got %b expected 1", dtack_a); end
        tick();
        Reset_L = 1'b1;
        tick();
    endtask

    task automatic test_read();
        bus_start(17'h0C123, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (blk_a !== 4'b0010) begin n_fails++; $display("FAIL read_blk: got %b expected 0010", blk_a); end
        n_checks++; if (addr_a !== 15'h4123) begin n_fails++; $display("FAIL read_addr: got %h expected 4123", addr_a); end
        n_checks++; if (oe_a !== 1'b1) begin n_fails++; $display("FAIL read_oe_w1: got %b expected 1", oe_a); end
        n_checks++; if (dtack_a !== 1'b1) begin n_fails++; $display("FAIL read_dtack_w1: got %b expected 1", dtack_a); end
        tick();
        n_checks++; if (oe_a !== 1'b1) begin n_fails++; $display("FAIL read_oe_w2: got %b expected 1", oe_a); end
        n_checks++; if (dtack_a !== 1'b1) begin n_fails++; $display("FAIL read_dtack_w2: got %b expected 1", dtack_a); end
        n_checks++; if (we_a !== 2'b00) begin n_fails++; $display("FAIL read_we: got %b expected 00", we_a); end
        tick();
        n_checks++; if (dtack_a !== 1'b0) begin n_fails++; $display("FAIL read_dtack_ack: got %b expected 0", dtack_a); end
        n_checks++; if (oe_a !== 1'b1) begin n_fails++; $display("FAIL read_oe_ack: got %b expected 1", oe_a); end
        n_checks++; if (blk_a !== 4'b0010) begin n_fails++; $display("FAIL read_blk_ack: got %b expected 0010", blk_a); end
        tick();
        n_checks++; if (dtack_a !== 1'b0) begin n_fails++; $display("FAIL read_dtack_hold: got %b expected 0", dtack_a); end
        bus_release();
        tick();
        n_checks++; if ({blk_a, oe_a, we_a, dtack_a} !== 8'b0000_0_00_1) begin
            n_fails++; $display("FAIL read_idle: got blk=%b oe=%b we=%b dtack=%b expected 0000/0/00/1", blk_a, oe_a, we_a, dtack_a);
        end
        tick();
    endtask

    task automatic test_write_lower();
        bus_start(17'h1FFFF, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++; if (blk_a !== 4'b1000) begin n_fails++; $display("FAIL wr_blk: got %b expected 1000", blk_a); end
        n_checks++; if (addr_a !== 15'h7FFF) begin n_fails++; $display("FAIL wr_addr: got %h expected 7fff", addr_a); end
        n_checks++; if (we_a !== 2'b01) begin n_fails++; $display("FAIL wr_we_w1: got %b expected 01", we_a); end
        n_checks++; if (oe_a !== 1'b0) begin n_fails++; $display("FAIL wr_oe_w1: got %b expected 0", oe_a); end
        tick();
        n_checks++; if (we_a !== 2'b01) begin n_fails++; $display("FAIL wr_we_w2: got %b expected 01", we_a); end
        n_checks++; if (dtack_a !== 1'b1) begin n_fails++; $display("FAIL wr_dtack_w2: got %b expected 1", dtack_a); end
        tick();
        n_checks++; if (we_a !== 2'b00) begin n_fails++; $display("FAIL wr_we_ack: got %b expected 00", we_a); end
        n_checks++; if (dtack_a !== 1'b0) begin n_fails++; $display("FAIL wr_dtack_ack: got %b expected 0", dtack_a); end
        n_checks++; if (oe_a !== 1'b0) begin n_fails++; $display("FAIL wr_oe_ack: got %b expected 0", oe_a); end
        n_checks++; if (blk_a !== 4'b1000) begin n_fails++; $display("FAIL wr_blk_ack: got %b expected 1000", blk_a); end
        bus_release();
        tick();
        n_checks++; if (blk_a !== 4'b0000) begin n_fails++; $display("FAIL wr_idle_blk: got %b expected 0000", blk_a); end
        tick();
    endtask

    task automatic test_zero_wait();
        bus_start(17'h00000, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (blk_z !== 4'b0001) begin n_fails++; $display("FAIL zw_blk: got %b expected 0001", blk_z); end
        n_checks++; if (oe_z !== 1'b1) begin n_fails++; $display("FAIL zw_oe: got %b expected 1", oe_z); end
        n_checks++; if (dtack_z !== 1'b1) begin n_fails++; $display("FAIL zw_dtack_wait: got %b expected 1", dtack_z); end
        tick();
        n_checks++; if (dtack_z !== 1'b0) begin n_fails++; $display("FAIL zw_dtack_ack: got %b expected 0", dtack_z); end
        n_checks++; if (blk_z !== 4'b0001) begin n_fails++; $display("FAIL zw_blk_ack: got %b expected 0001", blk_z); end
        bus_release();
        tick();
        n_checks++; if (dtack_z !== 1'b1) begin n_fails++; $display("FAIL zw_idle_dtack: got %b expected 1", dtack_z); end
        tick();
    endtask

    task automatic test_abort();
        int lows = 0;
        bus_start(17'h10005, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (blk_t !== 4'b0100) begin n_fails++; $display("FAIL ab_blk_wait: got %b expected 0100", blk_t); end
        n_checks++; if (addr_t !== 15'h0005) begin n_fails++; $display("FAIL ab_addr: got %h expected 0005", addr_t); end
        bus_release();
        tick();
        n_checks++; if (blk_t !== 4'b0000) begin n_fails++; $display("FAIL ab_blk_idle: got %b expected 0000", blk_t); end
        n_checks++; if (oe_t !== 1'b0) begin n_fails++; $display("FAIL ab_oe_idle: got %b expected 0", oe_t); end
        for (int i = 0; i < 6; i++) begin
            if (dtack_t === 1'b0) lows++;
            tick();
        end
        n_checks++; if (lows !== 0) begin n_fails++; $display("FAIL ab_dtack_never: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_not_selected();
        int activity = 0;
        Address = 17'h0C123; WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; SRamSelect_H = 1'b0; AS_L = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (blk_a !== 4'b0000 || oe_a !== 1'b0 || dtack_a !== 1'b1) activity++;
        end
        n_checks++; if (activity !== 0) begin n_fails++; $display("FAIL nosel_select: got %0d active cycles expected 0", activity); end
        activity = 0;
        SRamSelect_H = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (blk_a !== 4'b0000 || oe_a !== 1'b0 || dtack_a !== 1'b1) activity++;
        end
        n_checks++; if (activity !== 0) begin n_fails++; $display("FAIL nosel_strobes: got %0d active cycles expected 0", activity); end
        bus_release();
        tick();
    endtask

    task automatic test_no_retrigger();
        int lows = 0;
        int rises = 0;
        bus_start(17'h0C123, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            if (dtack_a === 1'b0) lows++;
            else rises++;
            tick();
        end
        n_checks++; if (lows !== 10) begin n_fails++; $display("FAIL noretrig_low: got %0d low cycles expected 10", lows); end
        n_checks++; if (rises !== 0) begin n_fails++; $display("FAIL noretrig_rise: got %0d high cycles expected 0", rises); end
        bus_release();
        tick();
        n_checks++; if (dtack_a !== 1'b1) begin n_fails++; $display("FAIL noretrig_idle: got %b expected 1", dtack_a); end
        tick();
    endtask

    task automatic test_addr_change();
        bus_start(17'h0C123, 1'b1, 1'b0, 1'b0);
        tick();
        Address = 17'h1FFFF; WE_L = 1'b0; UDS_L = 1'b1; SRamSelect_H = 1'b0;
        tick();
        n_checks++; if (addr_a !== 15'h4123) begin n_fails++; $display("FAIL chg_addr: got %h expected 4123", addr_a); end
        n_checks++; if (blk_a !== 4'b0010) begin n_fails++; $display("FAIL chg_blk: got %b expected 0010", blk_a); end
        n_checks++; if (oe_a !== 1'b1 || we_a !== 2'b00) begin
            n_fails++; $display("FAIL chg_dir: got oe=%b we=%b expected oe=1 we=00", oe_a, we_a);
        end
        tick();
        n_checks++; if (dtack_a !== 1'b0) begin n_fails++; $display("FAIL chg_dtack: got %b expected 0", dtack_a); end
        bus_release();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_write();
        bus_start(17'h08000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (we_a !== 2'b11) begin n_fails++; $display("FAIL rst_we_pre: got %b expected 11", we_a); end
        #2;
        Reset_L = 1'b0;
        #1;
        n_checks++; if (we_a !== 2'b00) begin n_fails++; $display("FAIL rst_we_async: got %b expected 00", we_a); end
        n_checks++; if (blk_a !== 4'b0000) begin n_fails++; $display("FAIL rst_blk_async: got %b expected 0000", blk_a); end
        n_checks++; if (dtack_a !== 1'b1) begin n_fails++; $display("FAIL rst_dtack_async: got %b expected 1", dtack_a); end
        bus_release();
        tick();
        Reset_L = 1'b1;
        tick();
        bus_start(17'h18010, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++; if (blk_a !== 4'b1000 || addr_a !== 15'h0010) begin
            n_fails++; $display("FAIL rst_after_latch: got blk=%b addr=%h expected 1000/0010", blk_a, addr_a);
        end
        tick();
        tick();
        n_checks++; if (dtack_a !== 1'b0) begin n_fails++; $display("FAIL rst_after_dtack: got %b expected 0", dtack_a); end
        bus_release();
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_lower();
        test_zero_wait();
        test_abort();
        test_not_selected();
        test_no_retrigger();
        test_addr_change();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Bus-cycle sequencer between the 68k asynchronous bus and the 256 KB on-chip SRAM (four 64 KB / 32K-word blocks).
- Qualifies an SRAM-selected bus cycle and latches the address, block, direction and byte lanes.
- Sequences block enables, output enable and byte write strobes over a programmable number of wait cycles, then returns DTACK to the CPU.
- Sits beside the top-level address decoder; drives the four SRAM block macros directly.

Parameters:
- READ_WAIT, 1, extra wait cycles for reads; range 0..15.
- WRITE_WAIT, 1, extra wait cycles for writes; range 0..15.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- Address  in  17  68k A17..A1 (word address). Bits [16:15] select the block; bits [14:0] are the word offset.
- SRamSelect_H  in  1  top-level decoder says the address is in SRAM.
- AS_L  in  1  68k address strobe.
- UDS_L  in  1  68k upper data strobe.
- LDS_L  in  1  68k lower data strobe.
- WE_L  in  1  68k R/W: 1 = read, 0 = write.
- BlockEn_H  out  4  one-hot block enable; bit n selects block n.
- SRamAddr  out  15  latched word offset into the block.
- OE_H  out  1  SRAM output enable (reads).
- ByteWE_H  out  2  write strobes; bit 1 = upper byte, bit 0 = lower byte.
- DtackOut_L  out  1  data transfer acknowledge to the 68k.

Behaviour:
- Reset values (asynchronous on Reset_L = 0, including mid-cycle): state IDLE, BlockEn_H = 0000, SRamAddr = 0, OE_H = 0, ByteWE_H = 00, DtackOut_L = 1, wait counter = 0.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- States: IDLE, WAIT, ACK.
- IDLE start condition: AS_L = 0, SRamSelect_H = 1, and at least one of UDS_L / LDS_L = 0.
  - On the start condition, latch Address[14:0] into SRamAddr, Address[16:15] into the block, and WE_L, ~UDS_L, ~LDS_L.
  - Load the counter with WRITE_WAIT for writes, READ_WAIT for reads. Go to WAIT.
- WAIT:
  - BlockEn_H is one-hot for the latched block.
  - Reads: OE_H = 1.
  - Writes: ByteWE_H = latched lanes (OE_H = 0).
  - Counter decrements each cycle. When the counter = 0, go to ACK on the next edge.
  - WAIT therefore lasts N+1 cycles (N = applicable wait parameter).
  - DtackOut_L first reads 0 exactly N+1 clocks after the start edge.
- ACK:
  - DtackOut_L = 0, BlockEn_H held.
  - Reads: OE_H held at 1 so data stays valid while the CPU latches it.
  - Writes: ByteWE_H = 00, so the write completes on the WAIT→ACK edge with address stable.
  - Stay in ACK until AS_L = 1, then go to IDLE with all outputs inactive.
- Abort: AS_L = 1 while in WAIT → IDLE on the next edge. All outputs go inactive and DTACK is never asserted.
- No retrigger: a new cycle is accepted only from IDLE. A held-low AS_L in ACK never restarts the cycle.
- Input changes after latching are ignored: Address, data strobes, WE_L and SRamSelect_H changing in WAIT/ACK have no effect.
- Not selected: SRamSelect_H = 0, or both data strobes high, → remain in IDLE with outputs inactive.
- Exactly one BlockEn_H bit is ever high, and only in WAIT/ACK.
- ByteWE_H and OE_H are never high together.
- Counter is 4 bits wide and never wraps below 0.

Test Plan:
- Read, READ_WAIT=1: Address = 0x0C123, UDS_L = LDS_L = 0, WE_L = 1, SRamSelect_H = 1 → BlockEn_H = 0010, SRamAddr = 0x4123, OE_H = 1 for 2 WAIT cycles. DtackOut_L = 0 on the 2nd clock after start and held until AS_L = 1, then all outputs inactive in 1 cycle.
- Write, lower byte only, WRITE_WAIT=1: Address = 0x1FFFF, LDS_L = 0, UDS_L = 1, WE_L = 0 → BlockEn_H = 1000, SRamAddr = 0x7FFF, ByteWE_H = 01 for exactly 2 cycles, then 00 with DtackOut_L = 0. OE_H stays 0 throughout.
- Zero-wait build (READ_WAIT = WRITE_WAIT = 0): word read at Address = 0 → WAIT for 1 cycle, DtackOut_L = 0 one clock after start, BlockEn_H = 0001.
- Abort: READ_WAIT = 3, AS_L released after 1 WAIT cycle → IDLE on the next edge, DtackOut_L never low, BlockEn_H = 0000.
- Guards: SRamSelect_H = 0 with AS_L = 0 → no output activity. AS_L held low 10 cycles after ACK → single DTACK, no second cycle. Address toggled during WAIT → SRamAddr and BlockEn_H unchanged.
- Reset mid-write: Reset_L = 0 during WAIT with ByteWE_H = 11 → ByteWE_H = 00, BlockEn_H = 0000, DtackOut_L = 1 immediately without waiting for a clock. After release, the next valid cycle completes normally.
